// File: rtl/data_mem_responder_if.sv
// Request/response bus between the Memory stage (master) and the data-memory
// responder (slave), including the stall request toward the hazard unit.
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic        busy;

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_fault, busy
   );

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_fault, busy
   );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder for the RV32I Memory stage: wait
// states, byte/halfword/word stores, sign/zero-extended loads, fault reporting.
module data_mem_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 2
) (
   input  logic clock,
   input  logic reset,
   data_mem_responder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

   stateT       state, nextState;
   logic [3:0]  waitCnt;
   logic        wrLatch;
   logic [2:0]  f3Latch;
   logic [31:0] addrLatch, wdataLatch;
   logic        accWrite;
   logic [2:0]  accF3;
   logic [31:0] accAddr, accWdata;
   logic        accFault, enterResp, doStore;
   logic [ADDR_WIDTH-1:0] wordIdx;
   logic [31:0] memWord, loadData, storeData;
   logic [7:0]  byteVal;
   logic [15:0] halfVal;
   logic [3:0]  byteEn;
   logic [31:0] rdataReg;
   logic        faultReg;
   logic [31:0] mem [2**ADDR_WIDTH];

   // In IDLE the live request is classified (and, with no wait states, executed)
   // directly; afterwards only the latched copy is used.
   always_comb begin
      accWrite = wrLatch;
      accF3    = f3Latch;
      accAddr  = addrLatch;
      accWdata = wdataLatch;
      if (state == IDLE) begin
         accWrite = bus.req_write;
         accF3    = bus.req_funct3;
         accAddr  = bus.req_addr;
         accWdata = bus.req_wdata;
      end
   end

   // Illegal funct3 (loads: 011/110/111, stores: anything but 000-010),
   // misalignment and out-of-range addresses all fault.
   always_comb begin
      accFault = 1'b0;
      if (accWrite)
         accFault = accF3[2] | (accF3[1:0] == 2'b11);
      else
         accFault = (accF3[1:0] == 2'b11) | (accF3 == 3'b110);
      if (accF3[1:0] == 2'b01 && accAddr[0])
         accFault = 1'b1;
      if (accF3[1:0] == 2'b10 && accAddr[1:0] != 2'b00)
         accFault = 1'b1;
      if ((accAddr >> (ADDR_WIDTH + 2)) != 32'd0)
         accFault = 1'b1;
   end

   assign wordIdx = accAddr[ADDR_WIDTH+1:2];
   assign memWord = mem[wordIdx];
   assign byteVal = memWord[{accAddr[1:0], 3'b000} +: 8];
   assign halfVal = accAddr[1] ? memWord[31:16] : memWord[15:0];

   always_comb begin
      loadData = memWord;
      case (accF3)
         3'b000:  loadData = {{24{byteVal[7]}}, byteVal};
         3'b001:  loadData = {{16{halfVal[15]}}, halfVal};
         3'b100:  loadData = {24'd0, byteVal};
         3'b101:  loadData = {16'd0, halfVal};
         default: loadData = memWord;
      endcase
   end

   // Store data is replicated across lanes so the byte enables alone pick the target.
   always_comb begin
      byteEn    = 4'b1111;
      storeData = accWdata;
      case (accF3[1:0])
         2'b00: begin
            byteEn    = 4'b0001 << accAddr[1:0];
            storeData = {4{accWdata[7:0]}};
         end
         2'b01: begin
            byteEn    = accAddr[1] ? 4'b1100 : 4'b0011;
            storeData = {2{accWdata[15:0]}};
         end
         default: begin
            byteEn    = 4'b1111;
            storeData = accWdata;
         end
      endcase
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE: if (bus.req_valid)
                  nextState = (accFault || WAIT_STATES == 0) ? RESP : WAIT;
         WAIT: if (waitCnt <= 4'd1) nextState = RESP;
         RESP: nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   assign enterResp = (nextState == RESP) && (state != RESP) && !reset;
   assign doStore   = enterResp && accWrite && !accFault;

   assign bus.req_ready  = (state == IDLE);
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_rdata = rdataReg;
   assign bus.resp_fault = faultReg;
   assign bus.busy       = (state == IDLE && bus.req_valid) || (state == WAIT);

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         waitCnt  <= 4'd0;
         rdataReg <= 32'd0;
         faultReg <= 1'b0;
      end else begin
         state <= nextState;
         if (state == IDLE && bus.req_valid && !accFault)
            waitCnt <= 4'(WAIT_STATES);
         else if (state == WAIT)
            waitCnt <= waitCnt - 4'd1;
         rdataReg <= 32'd0;
         faultReg <= 1'b0;
         if (enterResp) begin
            faultReg <= accFault;
            rdataReg <= (accFault || accWrite) ? 32'd0 : loadData;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && state == IDLE && bus.req_valid) begin
         wrLatch    <= bus.req_write;
         f3Latch    <= bus.req_funct3;
         addrLatch  <= bus.req_addr;
         wdataLatch <= bus.req_wdata;
      end
   end

   // Memory contents deliberately survive reset.
   always_ff @(posedge clock) begin
      if (doStore) begin
         for (int i = 0; i < 4; i++)
            if (byteEn[i]) mem[wordIdx][8*i +: 8] <= storeData[8*i +: 8];
      end
   end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder answering the load/store accesses issued by the pipelined RISC-V core's Memory stage. It accepts one request at a time, applies a configurable number of wait states, and performs RV32I byte, halfword and word stores and sign- or zero-extended loads. It returns a one-cycle response and drives a `busy` stall request toward the hazard unit.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits; memory is 2^ADDR_WIDTH x 32-bit words, indexed by `req_addr[ADDR_WIDTH+1:2]`.
- `WAIT_STATES`, default 2: extra cycles between acceptance and response; legal range 0..15.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  Memory stage presents an access.
- `req_write`  in  1  1 = store (MemWriteM), 0 = load.
- `req_funct3`  in  3  RV32I funct3 of the load/store.
- `req_addr`  in  32  byte address (ALU result).
- `req_wdata`  in  32  store data, right-aligned.
- `req_ready`  out  1  responder can accept a request this cycle.
- `resp_valid`  out  1  one-cycle pulse marking completion.
- `resp_rdata`  out  32  extended load data; 0 for stores and faults.
- `resp_fault`  out  1  valid with `resp_valid`: misaligned, illegal funct3 or out-of-range access.
- `busy`  out  1  stall request to the hazard unit.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch write, funct3, addr and wdata, then classify:
  - Fault if funct3 is illegal for the access type. Legal load funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Legal store funct3: 000 sb, 001 sh, 010 sw.
  - Fault if a halfword access has `addr[0]`=1, or a word access has `addr[1:0]`≠0.
  - Fault if `addr[31:ADDR_WIDTH+2]`≠0.
  - A faulting access goes to RESP and does not modify memory.
  - A non-faulting access loads the counter with WAIT_STATES and goes to WAIT. With WAIT_STATES=0 it goes directly to RESP.
- WAIT: `req_ready`=0. Decrement the counter each cycle. On the edge where the counter is 1, go to RESP.
- Memory access happens on the edge that enters RESP; the load result is registered into `resp_rdata` on that edge.
- Stores:
  - sb writes lane `addr[1:0]` with `wdata[7:0]`.
  - sh writes lanes {`addr[1]`*2, `addr[1]`*2+1} with `wdata[15:0]`.
  - sw writes all 4 lanes.
  - Other lanes are preserved.
- Loads: select the byte or halfword by address; lb/lh sign-extend, lbu/lhu zero-extend.
- RESP: `resp_valid`=1 and `req_ready`=0. The next state is IDLE unconditionally.
- `busy` = (IDLE & `req_valid`) | WAIT. It is combinational and is 0 in RESP, which releases the stall in the cycle the response is valid.
- Memory contents are not affected by reset.

## Timing
- Reset values: state IDLE, counter 0, `resp_valid` 0, `resp_rdata` 0, `resp_fault` 0. Consequently `req_ready` is 1 and `busy` follows `req_valid`.
- `req_valid` is ignored in any cycle where `reset` is high.
- Latency, with acceptance in cycle 0:
  - Non-faulting access: `resp_valid` in cycle WAIT_STATES+1.
  - Faulting access: `resp_valid` in cycle 1.
- `resp_rdata` and `resp_fault` are held only during the `resp_valid` cycle; they are 0 otherwise.
- Back-to-back: the earliest next acceptance is the cycle after RESP. The period is WAIT_STATES+2 cycles (2 for faults).
- Reset during WAIT or RESP: abort the access. A store not yet performed (reset asserted before the RESP-entry edge) never reaches memory. No `resp_valid` is produced after reset.
- Request fields change while not in IDLE: ignored; latched copies are used.

## Test plan
- WAIT_STATES=2, sw 0xDEADBEEF @0x10 accepted cycle 0:
  - `busy` high cycles 0–2, `resp_valid` cycle 3, `resp_fault` 0, `resp_rdata` 0.
  - Then lw @0x10 returns 0xDEADBEEF.
- Byte access after the sw above, sb 0x000000A5 @0x13:
  - lb @0x13 -> 0xFFFFFFA5; lbu @0x13 -> 0x000000A5.
  - lw @0x10 -> 0xA5ADBEEF.
- sh 0x00008001 @0x12:
  - lh @0x12 -> 0xFFFF8001; lhu -> 0x00008001.
  - lw @0x10 -> 0x8001BEEF, showing the lower half is preserved.
- Faults, each with `resp_valid` in cycle 1, `resp_fault`=1 and `rdata`=0:
  - lw @0x11.
  - sw @0x12; @0x10 is unchanged.
  - lw @0x00001000 with ADDR_WIDTH=10.
  - Load with funct3=011.
- Reset during WAIT of sw 0x12345678 @0x20:
  - No `resp_valid`; outputs are 0 the cycle after reset.
  - A later lw @0x20 returns the prior contents.
- `req_valid` held high for 20 cycles with WAIT_STATES=2:
  - Acceptances every 4 cycles.
  - `req_ready` low in WAIT/RESP.
  - Exactly one `resp_valid` per acceptance.
